// File: rtl/disp_frame_ctrl.sv
// Two-requester frame arbiter that pushes a 16-bit hex frame as four segment bytes to a display shift register.
// Optional macro DISP_LZB_EN enables leading-zero blanking of the pushed digits.
module disp_frame_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned HOLD_CYC = 1000
) (
  input  logic        clk,
  input  logic        start,
  input  logic        req_a,
  input  logic [15:0] frame_a,
  input  logic        req_b,
  input  logic [15:0] frame_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy,
  output logic [7:0]  Y,
  output logic        OE,
  output logic        scan_sgn
);

  localparam int unsigned CNT_W = 21;

  typedef enum logic [1:0] {IDLE, PUSH, HOLD} state_t;

  state_t           state, state_nx;
  logic             ptr, ptr_nx;
  logic [1:0]       idx, idx_nx;
  logic [15:0]      frame_q, frame_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [CNT_W-1:0] scan_cnt;
  logic             gnt_a_nx, gnt_b_nx, oe_nx, busy_nx;
  logic [7:0]       y_nx;
  logic             pick_b;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  // Segment byte for digit position pos (0 = rightmost nibble).
  function automatic logic [7:0] digit_seg(input logic [15:0] f, input logic [1:0] pos);
    logic [15:0] sh;
    sh = f >> {pos, 2'b00};
`ifdef DISP_LZB_EN
    if (pos != 2'd0 && sh == 16'd0) begin
      digit_seg = 8'hFF;
    end else begin
      digit_seg = hex_seg(sh[3:0]);
    end
`else
    digit_seg = hex_seg(sh[3:0]);
`endif
  endfunction

  // Round-robin: B wins when it is alone or when the pointer favours it.
  assign pick_b = req_b && (!req_a || ptr);

  always_ff @(posedge clk) begin
    if (start) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    frame_nx = frame_q;
    hold_nx  = hold_cnt;
    gnt_a_nx = 1'b0;
    gnt_b_nx = 1'b0;
    oe_nx    = 1'b0;
    y_nx     = 8'hFF;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          if (pick_b) begin
            gnt_b_nx = 1'b1;
            frame_nx = frame_b;
            ptr_nx   = 1'b0;
          end else begin
            gnt_a_nx = 1'b1;
            frame_nx = frame_a;
            ptr_nx   = 1'b1;
          end
          idx_nx   = 2'd0;
          state_nx = PUSH;
          oe_nx    = 1'b1;
          y_nx     = digit_seg(frame_nx, 2'd0);
        end
      end
      PUSH: begin
        if (idx == 2'd3) begin
          hold_nx  = '0;
          state_nx = (HOLD_CYC == 0) ? IDLE : HOLD;
        end else begin
          idx_nx = idx + 2'd1;
          oe_nx  = 1'b1;
          y_nx   = digit_seg(frame_q, idx + 2'd1);
        end
      end
      HOLD: begin
        if ((hold_cnt + CNT_W'(1)) >= CNT_W'(HOLD_CYC)) begin
          hold_nx  = '0;
          state_nx = IDLE;
        end else begin
          hold_nx = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Datapath and registered outputs follow the next-state decode.
  always_ff @(posedge clk) begin
    if (start) begin
      ptr      <= 1'b0;
      idx      <= 2'd0;
      frame_q  <= 16'd0;
      hold_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
      OE       <= 1'b0;
      Y        <= 8'hFF;
    end else begin
      ptr      <= ptr_nx;
      idx      <= idx_nx;
      frame_q  <= frame_nx;
      hold_cnt <= hold_nx;
      gnt_a    <= gnt_a_nx;
      gnt_b    <= gnt_b_nx;
      busy     <= busy_nx;
      OE       <= oe_nx;
      Y        <= y_nx;
    end
  end

  // Free-running scan divider; scan_sgn is high in the cycle the counter sits at its wrap value.
  always_ff @(posedge clk) begin
    if (start) begin
      scan_cnt <= '0;
      scan_sgn <= 1'b0;
    end else begin
      scan_cnt <= (scan_cnt == CNT_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + CNT_W'(1);
      scan_sgn <= (scan_cnt == CNT_W'(SCAN_DIV - 2));
    end
  end

endmodule

// File: tb/tb_disp_frame_ctrl.sv
// Self-checking bench for disp_frame_ctrl: two instances (HOLD_CYC=3 and HOLD_CYC=0) share stimulus
// and are compared every cycle against a transaction-level model, plus a directed vector table.
module tb_disp_frame_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        start, req_a, req_b;
  logic [15:0] frame_a, frame_b;
  logic [1:0]  gnt_a, gnt_b, busy, oe, scan;
  logic [7:0]  y [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  disp_frame_ctrl #(.SCAN_DIV(DIV), .HOLD_CYC(3)) dut0 (
    .clk(clk), .start(start), .req_a(req_a), .frame_a(frame_a), .req_b(req_b), .frame_b(frame_b),
    .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]), .busy(busy[0]), .Y(y[0]), .OE(oe[0]), .scan_sgn(scan[0]));

  disp_frame_ctrl #(.SCAN_DIV(DIV), .HOLD_CYC(0)) dut1 (
    .clk(clk), .start(start), .req_a(req_a), .frame_a(frame_a), .req_b(req_b), .frame_b(frame_b),
    .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]), .busy(busy[1]), .Y(y[1]), .OE(oe[1]), .scan_sgn(scan[1]));

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [16];
  int         hold_of [2];
  int         busy_left [2];
  int         npop [2];
  logic [7:0] bytes [2][4];
  logic       mptr [2];
  int         k = 0;
  logic       e_ga [2], e_gb [2], e_oe [2];
  logic [7:0] e_y [2];

  function automatic logic [7:0] enc(input logic [15:0] f, input int i);
    logic [15:0] sh;
    sh = f >> (4 * i);
`ifdef DISP_LZB_EN
    if (i > 0 && sh == 16'd0) return 8'hFF;
`endif
    return seg_tab[sh[3:0]];
  endfunction

  task automatic model_edge();
    logic       pb;
    logic [15:0] f;
    if (start) begin
      k = 1;
      for (int d = 0; d < 2; d++) begin
        busy_left[d] = 0; npop[d] = 0; mptr[d] = 1'b0;
        e_ga[d] = 1'b0; e_gb[d] = 1'b0; e_oe[d] = 1'b0; e_y[d] = 8'hFF;
      end
    end else begin
      k++;
      for (int d = 0; d < 2; d++) begin
        e_ga[d] = 1'b0; e_gb[d] = 1'b0;
        if (busy_left[d] > 0) begin
          busy_left[d]--;
        end else if (req_a || req_b) begin
          pb = req_b && (!req_a || mptr[d]);
          mptr[d] = !pb;
          f = pb ? frame_b : frame_a;
          for (int i = 0; i < 4; i++) bytes[d][i] = enc(f, i);
          npop[d] = 4;
          busy_left[d] = 4 + hold_of[d];
          e_ga[d] = !pb; e_gb[d] = pb;
        end
        if (npop[d] > 0) begin
          e_oe[d] = 1'b1; e_y[d] = bytes[d][4 - npop[d]]; npop[d]--;
        end else begin
          e_oe[d] = 1'b0; e_y[d] = 8'hFF;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("m_gnt_a", d, 16'(gnt_a[d]), 16'(e_ga[d]));
      chk("m_gnt_b", d, 16'(gnt_b[d]), 16'(e_gb[d]));
      chk("m_busy",  d, 16'(busy[d]),  16'(busy_left[d] > 0));
      chk("m_oe",    d, 16'(oe[d]),    16'(e_oe[d]));
      chk("m_y",     d, 16'(y[d]),     16'(e_y[d]));
      chk("m_scan",  d, 16'(scan[d]),  16'((k % DIV) == 0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic s, input logic ra, input logic [15:0] fa, input logic rb, input logic [15:0] fb);
    start = s; req_a = ra; frame_a = fa; req_b = rb; frame_b = fb;
  endtask

  // ---------------- directed vector table (checked on dut0) ----------------
  typedef struct {
    logic s, ra; logic [15:0] fa; logic rb; logic [15:0] fb;
    logic ga, gb, bz, o; logic [7:0] yy;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic ra, input logic [15:0] fa,
                              input logic ga, input logic bz, input logic o, input logic [7:0] yy);
    vec_t v;
    v.s = s; v.ra = ra; v.fa = fa; v.rb = 1'b0; v.fb = 16'h0;
    v.ga = ga; v.gb = 1'b0; v.bz = bz; v.o = o; v.yy = yy;
    return v;
  endfunction

`ifdef DISP_LZB_EN
  localparam logic [7:0] HI_ZERO = 8'hFF;
`else
  localparam logic [7:0] HI_ZERO = 8'hC0;
`endif

  vec_t tab [17];
  int   n, c0, last_oe;

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    hold_of[0] = 3; hold_of[1] = 0;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

    tab[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 8'hFF);
    tab[1]  = mk(0, 1, 16'h1234, 1, 1, 1, 8'h99);
    tab[2]  = mk(0, 0, 16'h0000, 0, 1, 1, 8'hB0);
    tab[3]  = mk(0, 0, 16'h0000, 0, 1, 1, 8'hA4);
    tab[4]  = mk(0, 0, 16'h0000, 0, 1, 1, 8'hF9);
    tab[5]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[6]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[7]  = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[8]  = mk(0, 0, 16'h0000, 0, 0, 0, 8'hFF);
    tab[9]  = mk(0, 1, 16'h0070, 1, 1, 1, 8'hC0);
    tab[10] = mk(0, 0, 16'h0000, 0, 1, 1, 8'hF8);
    tab[11] = mk(0, 0, 16'h0000, 0, 1, 1, HI_ZERO);
    tab[12] = mk(0, 0, 16'h0000, 0, 1, 1, HI_ZERO);
    tab[13] = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[14] = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[15] = mk(0, 0, 16'h0000, 0, 1, 0, 8'hFF);
    tab[16] = mk(0, 0, 16'h0000, 0, 0, 0, 8'hFF);

    for (int i = 0; i < 17; i++) begin
      drive(tab[i].s, tab[i].ra, tab[i].fa, tab[i].rb, tab[i].fb);
      step();
      chk($sformatf("t%0d_gnt_a", i), 0, 16'(gnt_a[0]), 16'(tab[i].ga));
      chk($sformatf("t%0d_gnt_b", i), 0, 16'(gnt_b[0]), 16'(tab[i].gb));
      chk($sformatf("t%0d_busy", i),  0, 16'(busy[0]),  16'(tab[i].bz));
      chk($sformatf("t%0d_oe", i),    0, 16'(oe[0]),    16'(tab[i].o));
      chk($sformatf("t%0d_y", i),     0, 16'(y[0]),     16'(tab[i].yy));
    end

    // Round-robin with both requests held from reset.
    drive(1, 0, 16'h0, 0, 16'h0); step();
    drive(0, 1, 16'hABCD, 1, 16'h5678); step();
    chk("arb_first_a", 0, 16'(gnt_a[0]), 16'd1);
    req_a = 1'b0;
    n = 0;
    do begin step(); n++; end while (!gnt_b[0] && n < 20);
    chk("arb_then_b", 0, 16'(gnt_b[0]), 16'd1);
    chk("arb_b_spacing", 0, 16'(n), 16'd8);
    req_b = 1'b0;
    n = 0;
    do begin step(); n++; end while ((busy[0] || busy[1]) && n < 20);
    chk("arb_idle_wait", 0, 16'(busy[0]), 16'd0);
    req_a = 1'b1; req_b = 1'b1; step();
    chk("arb_rr_back_to_a", 0, 16'(gnt_a[0]), 16'd1);
    chk("arb_rr_not_b", 0, 16'(gnt_b[0]), 16'd0);
    req_a = 1'b0; req_b = 1'b0;

    // Reset in the middle of a push aborts the frame.
    drive(1, 0, 16'h0, 0, 16'h0); step();
    drive(0, 1, 16'h9E3F, 0, 16'h0); step();
    req_a = 1'b0; step();
    chk("abort_second_oe", 0, 16'(oe[0]), 16'd1);
    start = 1'b1; step();
    chk("abort_oe", 0, 16'(oe[0]), 16'd0);
    chk("abort_y", 0, 16'(y[0]), 16'hFF);
    chk("abort_busy", 0, 16'(busy[0]), 16'd0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_oe", 0, 16'(oe[0]), 16'd0);
    end

    // scan_sgn keeps its cadence from reset release while a frame is pushed.
    drive(1, 0, 16'h0, 0, 16'h0); step();
    chk("scan_c1", 0, 16'(scan[0]), 16'd0);
    start = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      req_a = (c == 2);
      frame_a = 16'h4321;
      step();
      chk($sformatf("scan_c%0d", c), 0, 16'(scan[0]), 16'((c % 4) == 0));
    end
    req_a = 1'b0;

    // HOLD_CYC=0 back-to-back on dut1: one idle cycle between A's last OE and B's grant.
    drive(1, 0, 16'h0, 0, 16'h0); step();
    drive(0, 1, 16'h1111, 1, 16'h2222); step();
    chk("b2b_gnt_a", 1, 16'(gnt_a[1]), 16'd1);
    req_a = 1'b0;
    c0 = 0; last_oe = 0; n = 0;
    do begin
      if (oe[1]) last_oe = n;
      step(); n++;
    end while (!gnt_b[1] && n < 20);
    chk("b2b_gnt_b", 1, 16'(gnt_b[1]), 16'd1);
    chk("b2b_gap", 1, 16'(n - last_oe), 16'd2);
    req_b = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 79) == 0);
      req_a   = ($urandom_range(0, 2) != 0);
      req_b   = ($urandom_range(0, 2) != 0);
      frame_a = 16'($urandom) >> $urandom_range(0, 16);
      frame_b = 16'($urandom) >> $urandom_range(0, 16);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
